// File: rtl/iterative_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package iterative_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Iteration counter width; must be able to hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/iterative_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIVIDER_DBZ_FLAG_EN adds a registered div_by_zero result flag.
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    div_state_t       r_state;
    logic [WIDTH-1:0] r_dvd;      // dividend shifts out of the MSB, quotient bits enter the LSB
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_next;

    // Compare is WIDTH+1 wide so a divisor with its MSB set cannot overflow.
    always_comb begin
        w_trial    = {r_rem, r_dvd[WIDTH-1]};
        w_ge       = (w_trial >= {1'b0, r_divisor});
        w_diff     = w_trial[WIDTH-1:0] - r_divisor;
        w_rem_next = w_ge ? w_diff : w_trial[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef DIVIDER_DBZ_FLAG_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd     <= numerator;
                        r_divisor <= divisor;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                        r_state   <= CALC;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    quotient  <= r_dvd;
                    remainder <= r_rem;
                    done      <= 1'b1;
                    r_state   <= IDLE;
`ifdef DIVIDER_DBZ_FLAG_EN
                    div_by_zero <= (r_divisor == '0);
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider (WIDTH=32).
module tb_iterative_divider;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] numerator;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         busy;
`ifdef DIVIDER_DBZ_FLAG_EN
    logic         div_by_zero;
`endif

    int errors = 0;
    int checks = 0;

    iterative_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .numerator (numerator),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .busy      (busy)
`ifdef DIVIDER_DBZ_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start for exactly one rising edge.
    task automatic start_op(input logic [W-1:0] num, input logic [W-1:0] den);
        @(negedge clk);
        start     = 1'b1;
        numerator = num;
        divisor   = den;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Count negedges until done; busy must stay high the whole way.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = busy;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; numerator = '0; divisor = '0;
        repeat (3) @(negedge clk);
        checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef DIVIDER_DBZ_FLAG_EN
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        start_op(32'd100, 32'd10);
        wait_done(lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL basic_latency got=%0d exp=33", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bok); end
        checks++; if (quotient !== 32'd10) begin errors++; $display("FAIL basic_quotient got=%0d exp=10", quotient); end
        checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL basic_remainder got=%0d exp=0", remainder); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        checks++; if (quotient !== 32'd10) begin errors++; $display("FAIL basic_hold got=%0d exp=10", quotient); end
    endtask

    task automatic test_vectors();
        logic [W-1:0] t_num [6] = '{32'd123456, 32'd50000000, 32'd4294967295, 32'd0,     32'd50000000, 32'd50000000};
        logic [W-1:0] t_den [6] = '{32'd123,    32'd7,        32'd65535,      32'd12345, 32'd50000000, 32'd0};
        logic [W-1:0] t_q   [6] = '{32'd1003,   32'd7142857,  32'd65537,      32'd0,     32'd1,        32'hFFFFFFFF};
        logic [W-1:0] t_r   [6] = '{32'd87,     32'd1,        32'd0,          32'd0,     32'd0,        32'd50000000};
        int lat;
        bit bok;
        for (int i = 0; i < 6; i++) begin
            start_op(t_num[i], t_den[i]);
            wait_done(lat, bok);
            checks++; if (lat !== 33) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=33", i, lat); end
            checks++; if (quotient !== t_q[i]) begin errors++; $display("FAIL vec%0d_quotient got=%h exp=%h", i, quotient, t_q[i]); end
            checks++; if (remainder !== t_r[i]) begin errors++; $display("FAIL vec%0d_remainder got=%h exp=%h", i, remainder, t_r[i]); end
`ifdef DIVIDER_DBZ_FLAG_EN
            checks++;
            if (div_by_zero !== (t_den[i] == 32'd0)) begin
                errors++; $display("FAIL vec%0d_dbz got=%b exp=%b", i, div_by_zero, (t_den[i] == 32'd0));
            end
`endif
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        bit bok;
        start_op(32'd500, 32'd5);
        repeat (5) @(negedge clk);
        start = 1'b1; numerator = 32'd7; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bok);
        checks++; if (lat + 6 !== 33) begin errors++; $display("FAIL ignore_latency got=%0d exp=33", lat + 6); end
        checks++; if (quotient !== 32'd100) begin errors++; $display("FAIL ignore_quotient got=%0d exp=100", quotient); end
        checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL ignore_remainder got=%0d exp=0", remainder); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n_done;
        bit bok;
        start_op(32'd999, 32'd4);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL rstmid_quotient got=%0d exp=0", quotient); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", n_done); end
        start_op(32'd1000, 32'd3);
        wait_done(lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL rstmid_latency got=%0d exp=33", lat); end
        checks++; if (quotient !== 32'd333) begin errors++; $display("FAIL rstmid_quotient2 got=%0d exp=333", quotient); end
        checks++; if (remainder !== 32'd1) begin errors++; $display("FAIL rstmid_remainder2 got=%0d exp=1", remainder); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        @(negedge clk);
        start = 1'b1; numerator = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        wait_done(lat, bok);
        checks++; if (quotient !== 32'd333) begin errors++; $display("FAIL b2b_first got=%0d exp=333", quotient); end
        numerator = 32'd77; divisor = 32'd7;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got=%b exp=0", done); end
        wait_done(lat, bok);
        checks++; if (lat + 1 !== 34) begin errors++; $display("FAIL b2b_gap got=%0d exp=34", lat + 1); end
        checks++; if (quotient !== 32'd11) begin errors++; $display("FAIL b2b_quotient got=%0d exp=11", quotient); end
        checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL b2b_remainder got=%0d exp=0", remainder); end
        start = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
